// File: rtl/picmicro_return_stack.sv
// Return-address stack for the picmicro PC unit.
// Circular or saturating overflow policy, sticky ovf/unf, high-water mark.
module picmicro_return_stack #(
  parameter int WIDTH     = 13,
  parameter int DEPTH     = 8,
  parameter bit MODE_WRAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_en,
  input  logic                     pop_en,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     flush,
  input  logic                     clr_flags,
  output logic [WIDTH-1:0]         out,
  output logic [$clog2(DEPTH):0]   tos,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf,
  output logic [$clog2(DEPTH):0]   high_water
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [AW-1:0]    ptr, ptr_n, top, waddr;
  logic [CW-1:0]    count, cnt_n, hw, hw_n;
  logic             we, ovf_ev, unf_ev;
  logic             do_push, do_pop, do_rep;

  assign top   = ptr - 1'b1;
  assign full  = (count == FULLC);
  assign empty = (count == '0);
  assign tos   = count;
  assign high_water = hw;
  assign out   = empty ? '0 : stack[top];

  assign do_push = push_en & ~pop_en & ~flush;
  assign do_pop  = pop_en & ~push_en & ~flush;
  assign do_rep  = push_en & pop_en & ~flush;

  always_comb begin
    ptr_n  = ptr;
    cnt_n  = count;
    we     = 1'b0;
    waddr  = ptr;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    unique case (1'b1)
      flush: begin
        ptr_n = '0;
        cnt_n = '0;
      end
      do_push: begin
        if (!full) begin
          we    = 1'b1;
          ptr_n = ptr + 1'b1;
          cnt_n = count + 1'b1;
        end else begin
          ovf_ev = 1'b1;
          if (MODE_WRAP) begin
            we    = 1'b1;
            ptr_n = ptr + 1'b1;
          end
        end
      end
      do_pop: begin
        if (!empty) begin
          ptr_n = top;
          cnt_n = count - 1'b1;
        end else begin
          unf_ev = 1'b1;
          if (MODE_WRAP) ptr_n = top;
        end
      end
      do_rep: begin
        we = 1'b1;
        if (!empty) begin
          waddr = top;
        end else begin
          // Replace on an empty stack degrades to a plain push.
          ptr_n  = ptr + 1'b1;
          cnt_n  = count + 1'b1;
          unf_ev = 1'b1;
        end
      end
      default: ;
    endcase
    if (flush) hw_n = '0;
    else       hw_n = (cnt_n > hw) ? cnt_n : hw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      hw    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ptr   <= ptr_n;
      count <= cnt_n;
      hw    <= hw_n;
      ovf   <= ovf_ev | (ovf & ~clr_flags);
      unf   <= unf_ev | (unf & ~clr_flags);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we) stack[waddr] <= push_data;
  end

endmodule
